// File: rtl/alu4_arbiter_pkg.sv
// Shared definitions for the two-requester alu4 arbiter: opcodes, FSM states, flag bit positions.
// Pure definitions, no logic; no latency or backpressure of its own.
package alu4_arbiter_pkg;

    localparam logic [2:0] OP_NOTA = 3'b000;
    localparam logic [2:0] OP_NOTB = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SUB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu4_arbiter_alu4.sv
// 4-bit ALU producing result and {c,n,z,v} flags from one opcode and two operands.
// Purely combinational (zero latency); no handshake, so it never backpressures.
module alu4
    import alu4_arbiter_pkg::*;
(
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] result,
    output logic [3:0] flags
);

    logic [4:0] sum;
    logic       carry;
    logic       ovf;

    always_comb begin
        sum    = 5'd0;
        result = 4'd0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_NOTA: result = ~a;
            OP_NOTB: result = ~b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[3:0];
                carry  = sum[4];
                ovf    = (a[3] == b[3]) && (result[3] != a[3]);
            end
            OP_SUB: begin
                // a + ~b + 1, so carry out of 1 means no borrow.
                sum    = {1'b0, a} + {1'b0, ~b} + 5'd1;
                result = sum[3:0];
                carry  = sum[4];
                ovf    = (a[3] != b[3]) && (result[3] != a[3]);
            end
            default: result = 4'd0;
        endcase
    end

    always_comb begin
        flags         = 4'd0;
        flags[FLAG_C] = carry;
        flags[FLAG_N] = result[3];
        flags[FLAG_Z] = (result == 4'd0);
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu4_arbiter.sv
// Round-robin arbiter sharing one alu4 between two valid/ready requesters; registered, id-tagged response.
// Three cycles per op (accept, execute, respond); no new accepts until the response is taken by rsp_ready.
module alu4_arbiter
    import alu4_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [2:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic [3:0] rsp_flags,
    input  logic       rsp_ready
);

    state_t     state;
    logic       last_grant;
    logic       id_q;
    logic [2:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;

    logic       grant_id;
    logic       accept;
    logic [3:0] alu_result;
    logic [3:0] alu_flags;

    // On a tie the requester not served last wins; otherwise whoever is valid.
    assign grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign accept     = reset_n && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    alu4 U0_alu4 (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            op_q       <= 3'd0;
            a_q        <= 4'd0;
            b_q        <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 4'd0;
            rsp_flags  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        op_q       <= grant_id ? req1_op : req0_op;
                        a_q        <= grant_id ? req1_a  : req0_a;
                        b_q        <= grant_id ? req1_b  : req0_b;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_arbiter.sv
// Directed bench for alu4_arbiter: reset, contention, single op, backpressure, logic ops, reset mid-EXEC.
// Inputs change and outputs are sampled around the falling edge, away from the active edge.
module tb_alu4_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_ready;
    logic [3:0] rsp_result, rsp_flags;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu4_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_ready  (rsp_ready)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Single-requester transaction with rsp_ready held high; starts and ends at a falling edge in IDLE.
    task automatic run_op(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_r, input logic [3:0] exp_f, input string tag);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        chk({tag, "_ready0"}, {3'b0, req0_ready}, {3'b0, !id});
        chk({tag, "_ready1"}, {3'b0, req1_ready}, {3'b0, id});
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk({tag, "_exec_vld"}, {3'b0, rsp_valid}, 4'd0);
        chk({tag, "_exec_rdy"}, {3'b0, req0_ready | req1_ready}, 4'd0);
        @(negedge clk);
        chk({tag, "_rsp_vld"}, {3'b0, rsp_valid}, 4'd1);
        chk({tag, "_rsp_id"}, {3'b0, rsp_id}, {3'b0, id});
        chk({tag, "_result"}, rsp_result, exp_r);
        chk({tag, "_flags"}, rsp_flags, exp_f);
        @(negedge clk);
        chk({tag, "_done_vld"}, {3'b0, rsp_valid}, 4'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        rsp_ready  = 1'b1;
        // Contention payloads presented through reset: readys must stay low.
        req0_valid = 1'b1; req0_op = 3'b111; req0_a = 4'b0101; req0_b = 4'b0101;
        req1_valid = 1'b1; req1_op = 3'b111; req1_a = 4'b1010; req1_b = 4'b0101;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", {3'b0, rsp_valid}, 4'd0);
        chk("rst_rsp_result", rsp_result, 4'b0000);
        chk("rst_rsp_flags", rsp_flags, 4'b0000);
        chk("rst_rsp_id", {3'b0, rsp_id}, 4'd0);
        chk("rst_ready0", {3'b0, req0_ready}, 4'd0);
        chk("rst_ready1", {3'b0, req1_ready}, 4'd0);

        reset_n = 1'b1;
        #1;
        chk("tie_first_ready0", {3'b0, req0_ready}, 4'd1);
        chk("tie_first_ready1", {3'b0, req1_ready}, 4'd0);

        // Contention: grants alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            int waited;
            waited = 0;
            while (!rsp_valid && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            chk("cont_rsp_valid", {3'b0, rsp_valid}, 4'd1);
            chk("cont_rsp_id", {3'b0, rsp_id}, {3'b0, k[0]});
            chk("cont_result", rsp_result, k[0] ? 4'b0101 : 4'b0000);
            chk("cont_flags", rsp_flags, k[0] ? 4'b1001 : 4'b1010);
            chk("cont_resp_readys", {2'b0, req1_ready, req0_ready}, 4'd0);
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("cont_idle_vld", {3'b0, rsp_valid}, 4'd0);

        run_op(1'b0, 3'b110, 4'b0100, 4'b0100, 4'b1000, 4'b0101, "add");

        // Backpressure: req1 XOR held in RESP while req0 waits with AND.
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_op = 3'b100; req1_a = 4'b0011; req1_b = 4'b0101;
        #1;
        chk("bp_ready1", {3'b0, req1_ready}, 4'd1);
        chk("bp_ready0", {3'b0, req0_ready}, 4'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 4'b0101; req0_b = 4'b1001;
        #1;
        chk("bp_exec_ready0", {3'b0, req0_ready}, 4'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_vld", {3'b0, rsp_valid}, 4'd1);
            chk("bp_hold_id", {3'b0, rsp_id}, 4'd1);
            chk("bp_hold_result", rsp_result, 4'b0110);
            chk("bp_hold_flags", rsp_flags, 4'b0000);
            chk("bp_hold_readys", {2'b0, req1_ready, req0_ready}, 4'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready0", {3'b0, req0_ready}, 4'd0);
        @(negedge clk);
        chk("bp_done_vld", {3'b0, rsp_valid}, 4'd0);
        chk("bp_idle_ready0", {3'b0, req0_ready}, 4'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("and_rsp_vld", {3'b0, rsp_valid}, 4'd1);
        chk("and_rsp_id", {3'b0, rsp_id}, 4'd0);
        chk("and_result", rsp_result, 4'b0001);
        chk("and_flags", rsp_flags, 4'b0000);
        @(negedge clk);

        run_op(1'b1, 3'b000, 4'b0000, 4'b0101, 4'b1111, 4'b0100, "nota");
        run_op(1'b0, 3'b011, 4'b0101, 4'b1010, 4'b1111, 4'b0100, "or");

        // Reset in EXEC: last grant was 0, so this tie goes to requester 1 first.
        req0_valid = 1'b1; req0_op = 3'b110; req0_a = 4'b0001; req0_b = 4'b0001;
        req1_valid = 1'b1; req1_op = 3'b110; req1_a = 4'b0010; req1_b = 4'b0010;
        #1;
        chk("rexec_ready1", {3'b0, req1_ready}, 4'd1);
        chk("rexec_ready0", {3'b0, req0_ready}, 4'd0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rexec_rst_vld", {3'b0, rsp_valid}, 4'd0);
        chk("rexec_rst_readys", {2'b0, req1_ready, req0_ready}, 4'd0);
        @(negedge clk);
        chk("rexec_rst_vld2", {3'b0, rsp_valid}, 4'd0);
        chk("rexec_rst_result", rsp_result, 4'b0000);
        reset_n = 1'b1;
        #1;
        chk("rexec_tie_ready0", {3'b0, req0_ready}, 4'd1);
        chk("rexec_tie_ready1", {3'b0, req1_ready}, 4'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rexec_no_rsp", {3'b0, rsp_valid}, 4'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu4_arbiter.md
# alu4_arbiter

Round-robin arbiter and sequencer sharing one `alu4` between two requesters. Each requester presents an op/operand pair with a valid/ready handshake. The block latches the winning request, executes it on the internal `alu4`, and returns the registered result and flags on a shared response port tagged with the requester id. It sits between two independent control units and the single 4-bit ALU resource.

## Interface
- No parameters. Requester count is fixed at 2 and data width at 4.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a pending op.
- `req0_op` in 3: ALU opcode. 000 ~a, 001 ~b, 010 a&b, 011 a|b, 100 a^b, 101 ~(a^b), 110 a+b, 111 a-b.
- `req0_a`, `req0_b` in 4: operands.
- `req0_ready` out 1: request 0 accepted this cycle.
- `req1_valid`, `req1_op`, `req1_a`, `req1_b` in and `req1_ready` out: same as requester 0, for requester 1.
- `rsp_valid` out 1: response available.
- `rsp_id` out 1: requester that issued the response.
- `rsp_result` out 4: ALU result.
- `rsp_flags` out 4: {c, n, z, v}.
- `rsp_ready` in 1: consumer accepts the response.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If any `reqX_valid` is high, grant one requester and assert its `reqX_ready` combinationally for that cycle.
  - On the clock edge, latch op/a/b and the grant id, then go to EXEC.
  - No valid request: stay in IDLE.
- **Arbitration:**
  - Only one valid: grant it.
  - Both valid: grant the requester not granted last.
  - `last_grant` updates at acceptance.
- **EXEC:** `alu4` operates on the latched operands. On the edge, register result, flags and id into the `rsp_*` registers, set `rsp_valid`, and go to RESP.
- **RESP:**
  - Hold `rsp_valid` and all `rsp_*` stable until `rsp_ready` is sampled high.
  - On `rsp_valid && rsp_ready`: clear `rsp_valid` and go to IDLE.
  - New requests are not accepted in RESP or EXEC; both `reqX_ready` are 0.
- **Requester rules:** hold valid and payload stable until ready. Dropping valid before ready is legal; that request is simply not taken.
- **Flags** (4-bit two's-complement arithmetic):
  - n = result[3].
  - z = (result == 0).
  - ADD: c = carry out of a+b; v = signed overflow.
  - SUB: computed as a + ~b + 1; c = carry out (1 means no borrow); v = signed overflow.
  - Logic ops: c = 0, v = 0.
- **Reset (async, any state):**
  - State = IDLE, `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_flags` = 0, operand registers = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
  - Both `reqX_ready` = 0 while `reset_n` is low.
- **Reset mid-operation:** an in-flight request is discarded with no response; the requester must re-issue it.

## Timing
- Acceptance at edge T (ready high during cycle T-1→T): state EXEC after T, `rsp_valid` high after edge T+1.
- Minimum loop is 3 cycles per op: IDLE accept, EXEC, RESP with `rsp_ready` already high.
- `rsp_*` outputs are registered with no combinational path from `reqX_*`.
- `reqX_ready` is combinational from state, `reqX_valid` and `last_grant` only, never from `rsp_ready`.
- Simultaneous `rsp_ready` and new `reqX_valid` in RESP: the response completes, and the new request is accepted no earlier than the following IDLE cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.

## Structure
- Shared package/header holds:
  - opcode constants (OP_NOTA..OP_SUB, 3-bit);
  - FSM state encodings (IDLE/EXEC/RESP, 2-bit);
  - flag bit positions (C=3, N=2, Z=1, V=0).
- One sub-module: the existing `alu4`, instantiated as `U0_alu4` and fed from the latched operand registers. Arbitration and FSM live in `alu4_arbiter`.

## Test plan
- **Reset:** hold `reset_n` low 3 cycles → `rsp_valid` 0, `rsp_result` 0000, `rsp_flags` 0000, both readys 0. After release with both valid, `req0_ready` is 1 first.
- **Single ADD:** req0 ADD 0100+0100 → `req0_ready` 1 for one cycle, `rsp_valid` 2 edges later with id 0, result 1000, flags c0 n1 z0 v1.
- **Contention:** both valid continuously.
  - req0 SUB 0101-0101 → result 0000, c1 z1 n0 v0.
  - req1 SUB 1010-0101 → result 0101, c1 v1.
  - Responses are ordered 0,1,0,1 and `rsp_id` alternates.
- **Backpressure:** hold `rsp_ready` low 5 cycles after req1 XOR 0011^0101 → result 0110 and flags 0000 stay stable, `rsp_valid` stays 1, both readys stay 0. Release → completes and returns to IDLE next cycle.
- **Logic ops:** ~a with a=0000 → 1111 (n1). OR 0101|1010 → 1111. AND 0101&1001 → 0001, c0 v0 in all cases.
- **Reset in EXEC:** assert `reset_n` low mid-EXEC → `rsp_valid` stays 0 with no response emitted. After release, the tie goes to requester 0.
